// File: rtl/tick_gen_multi.sv
// tick_gen_multi: multi-channel programmable periodic tick generator.
// Each channel divides clk by (period + 1) and emits a one-cycle registered
// pulse. A common sync input restarts all channels phase-aligned.
// Optional build feature: define TICK_GEN_ONESHOT_EN to enable per-channel
// one-shot mode. When it is undefined, the oneshot port has no effect.
module tick_gen_multi #(
    parameter int NUM_CH       = 4,
    parameter int DIV_W        = 24,
    parameter int RESET_PERIOD = 9999999
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      sync,
    input  logic [NUM_CH-1:0]         en,
    input  logic [NUM_CH-1:0]         load,
    input  logic [NUM_CH*DIV_W-1:0]   period_in,
    input  logic [NUM_CH-1:0]         oneshot,
    output logic [NUM_CH-1:0]         pulse,
    output logic [NUM_CH-1:0]         busy
);

`ifdef TICK_GEN_ONESHOT_EN
    localparam logic ONESHOT_EN = 1'b1;
`else
    localparam logic ONESHOT_EN = 1'b0;
`endif

    localparam logic [DIV_W-1:0] RST_PERIOD = DIV_W'(RESET_PERIOD);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DIV_W-1:0] cnt;
        logic [DIV_W-1:0] period_reg;
        logic             armed;
        logic             en_q;
        logic             pulse_q;
        logic             busy_q;
        logic             arm_eff;
        logic             at_tc;
        logic             stop_at_tc;

        // A rising en re-arms a channel that a one-shot terminal count disarmed;
        // with the feature compiled out, stop_at_tc is constant 0 and armed stays 1.
        always_comb begin
            arm_eff    = armed | (en[i] & ~en_q);
            at_tc      = (cnt >= period_reg);
            stop_at_tc = oneshot[i] & ONESHOT_EN;
        end

        // Per-channel counter, period latch, arm state and registered outputs.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt        <= '0;
                period_reg <= RST_PERIOD;
                armed      <= 1'b1;
                en_q       <= 1'b0;
                pulse_q    <= 1'b0;
                busy_q     <= 1'b0;
            end else begin
                en_q <= en[i];
                if (sync || load[i]) begin
                    // load still latches its period when it coincides with sync
                    if (load[i]) begin
                        period_reg <= period_in[i*DIV_W +: DIV_W];
                    end
                    cnt     <= '0;
                    pulse_q <= 1'b0;
                    armed   <= 1'b1;
                    busy_q  <= en[i];
                end else if (!en[i]) begin
                    cnt     <= '0;
                    pulse_q <= 1'b0;
                    busy_q  <= 1'b0;
                end else if (arm_eff) begin
                    if (at_tc) begin
                        cnt     <= '0;
                        pulse_q <= 1'b1;
                        armed   <= ~stop_at_tc;
                        busy_q  <= ~stop_at_tc;
                    end else begin
                        cnt     <= cnt + DIV_W'(1);
                        pulse_q <= 1'b0;
                        armed   <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end else begin
                    cnt     <= '0;
                    pulse_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            end
        end

        assign pulse[i] = pulse_q;
        assign busy[i]  = busy_q;
    end

endmodule

// File: doc/tick_gen_multi.md
Name: tick_gen_multi

Overview:
Multi-channel programmable periodic tick generator. It is the parametrised successor of the fixed 0.1 s pulse divider and replaces it in all timing paths. Each of NUM_CH channels divides the 100 MHz system clock by a runtime-loadable period and emits a one-cycle registered pulse. A common sync input restarts all channels phase-aligned. One-shot mode is an optional build feature.

Parameters:
NUM_CH, 4, number of independent tick channels (1..16)
DIV_W, 24, width of each channel's period register and counter
RESET_PERIOD, 9999999, period value loaded at reset (0.1 s at 100 MHz); must fit in DIV_W bits

Ports:
clk  input  1  system clock (100 MHz)
rst_n  input  1  asynchronous active-low reset
sync  input  1  restart all channels: counters cleared, re-armed
en  input  NUM_CH  per-channel enable, bit i = channel i
load  input  NUM_CH  per-channel strobe: latch the new period
period_in  input  NUM_CH*DIV_W  new periods; channel i uses bits [i*DIV_W +: DIV_W]
oneshot  input  NUM_CH  per-channel mode: 1 = one-shot, 0 = periodic (used only with TICK_GEN_ONESHOT_EN)
pulse  output  NUM_CH  per-channel tick, registered, 1 clk wide
busy  output  NUM_CH  per-channel: en[i] AND armed[i], registered

Behaviour:
- Reset: one clock; rst_n is asynchronous and active-low. While low: all cnt=0, pulse=0, period_reg=RESET_PERIOD, armed=1, busy=0.
- Per-channel state: cnt[DIV_W], period_reg[DIV_W], armed. Channels are fully independent except for sync.
- Priority per channel, each clk edge: rst_n > sync > load[i] > en[i] count.
- sync=1: cnt<=0, pulse<=0, armed<=1 on all channels. Pending load[i] in the same cycle still updates period_reg.
- load[i]=1: period_reg<=period_in slice, cnt<=0, pulse<=0, armed<=1. Applies regardless of en[i].
- en[i]=0: cnt<=0, pulse<=0. armed is unchanged. On re-enable, counting restarts from 0.
- en[i]=1 and armed[i]=1: if cnt>=period_reg then cnt<=0 and pulse<=1; else cnt<=cnt+1 and pulse<=0.
- Period P gives one pulse every P+1 clks. The first pulse is registered on the (P+1)th edge at which en is high, counting from the enable, load or sync.
- P=0 with en held high: pulse is continuously 1.
- A period change takes effect only via load. There is no on-the-fly retarget mid-count.
- Comparison is >=, so a cnt left above the period cannot run away. The counter never wraps past 2^DIV_W-1.
- busy[i] is registered: en[i] AND armed[i], updated every edge.

Optional Feature:
- Macro: TICK_GEN_ONESHOT_EN.
- Defined: a channel with oneshot[i]=1 clears armed[i] on the edge that sets pulse[i]. It then holds cnt=0 and pulse=0 until load[i], sync, or en[i] falls and rises again. Re-enable sets armed<=1.
- oneshot[i] is sampled every cycle. Changing it mid-count affects only the next terminal count.
- Not defined: the oneshot port is ignored, armed is constant 1, all channels are periodic, and busy[i] equals registered en[i].

Test Plan:
- Reset default: rst_n low then high, en=4'b0001, no load -> pulse[0] every 10,000,000 clks, first pulse after 10,000,000 enabled edges; other pulse bits stay 0.
- Load and period: load channel 1 with P=4, en[1]=1 -> pulse[1] high exactly every 5th clk, 1 clk wide. P=0 -> pulse[1] constantly high.
- Sync alignment: ch0 P=3, ch2 P=7, running out of phase; pulse sync -> both pulse together 4 and 8 clks later, and ch0 pulses every 4 clks thereafter.
- Load mid-count: ch3 P=100 at cnt=50, load P=10 -> no pulse for 10 clks, then pulse 11 clks after the load edge, then every 11.
- One-shot (TICK_GEN_ONESHOT_EN): ch0 oneshot=1, P=5 -> single pulse 6 clks after enable, busy[0] falls with it, no further pulses; toggling en[0] -> exactly one more pulse. Macro undefined -> periodic pulses.
- Async reset mid-count: drop rst_n between edges with cnt nonzero -> pulse and busy 0 immediately, without waiting for a clk edge; after release, period is back to RESET_PERIOD.
